// File: rtl/encoder8_3_serial.sv
// encoder8_3_serial
//   Clocked 8-to-3 encoder. Captures an 8-bit request vector and emits the
//   3-bit index of every set bit, one index per output beat, in priority
//   order. An all-zero vector produces a single beat flagged with none_hot.
//
//   Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high. Once the producer raises a valid, the payload it qualifies is
//   held stable until that transfer. in_ready depends on state only.
//
// Parameters
//   PRIO_MSB   1: highest set bit first (7..0); 0: lowest set bit first (0..7)
//
// Ports
//   sys_clk    in   system clock, rising edge
//   sys_rst_n  in   asynchronous reset, active low
//   in         in   [7:0] request vector, captured on in_valid & in_ready
//   in_valid   in   request vector present
//   in_ready   out  idle and able to accept a vector (combinational)
//   out        out  [2:0] index of the current set bit
//   out_valid  out  out, out_last and none_hot are valid
//   out_ready  in   consumer accepts the current beat
//   out_last   out  current beat is the final one for the captured vector
//   none_hot   out  captured vector was zero (qualified by out_valid)
//   hot_cnt    out  [3:0] set-bit count of the captured vector, held until
//                   the next capture
//   dbg_state  out  current FSM state (0 = IDLE, 1 = EMIT)
module encoder8_3_serial #(
    parameter bit PRIO_MSB = 1'b1
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [2:0] out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       none_hot,
    output logic [3:0] hot_cnt,
    output logic       dbg_state
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t     state;
    logic [7:0] pend;
    logic [7:0] rest;

    // Index of the priority bit; a zero vector yields index 0. The scan runs
    // from the low-priority end so the last match is the winner.
    function automatic logic [2:0] prio_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (PRIO_MSB) begin
                if (v[i]) idx = 3'(i);
            end else begin
                if (v[7-i]) idx = 3'(7 - i);
            end
        end
        return idx;
    endfunction

    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + 4'(v[i]);
        end
        return cnt;
    endfunction

    // Pending bits left once the beat currently on out is accepted.
    always_comb begin
        rest = pend & ~(8'b1 << out);
    end

    assign in_ready  = (state == IDLE);
    assign dbg_state = state;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            pend      <= 8'h00;
            out       <= 3'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            none_hot  <= 1'b0;
            hot_cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // First beat is loaded on the capture edge itself.
                        pend      <= in;
                        hot_cnt   <= popcount(in);
                        out       <= prio_idx(in);
                        out_last  <= (popcount(in) <= 4'd1);
                        none_hot  <= (in == 8'h00);
                        out_valid <= 1'b1;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (rest != 8'h00) begin
                            pend     <= rest;
                            out      <= prio_idx(rest);
                            out_last <= (popcount(rest) == 4'd1);
                        end else begin
                            pend      <= 8'h00;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            none_hot  <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
